// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: RV32I funct3 encodings,
// FSM state type and the byte-lane helpers used when issuing a request.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  function automatic logic legal_load(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: legal_load = 1'b1;
      default:                        legal_load = 1'b0;
    endcase
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: legal_store = 1'b1;
      default:          legal_store = 1'b0;
    endcase
  endfunction

  // Bytes are always aligned; halfwords need addr[0]=0; words need addr[1:0]=00.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: is_aligned = 1'b1;
      F3_H, F3_HU: is_aligned = ~lo[0];
      default:     is_aligned = (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: byte_en = 4'b0001 << lo;
      F3_H, F3_HU: byte_en = 4'b0011 << {lo[1], 1'b0};
      default:     byte_en = 4'b1111;
    endcase
  endfunction

  // Replicating the store data lets memory pick its lane purely from byte enables.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B, F3_BU: store_data = {4{wd[7:0]}};
      F3_H, F3_HU: store_data = {2{wd[15:0]}};
      default:     store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data extraction: selects the addressed lane of a
// memory word and sign- or zero-extends it according to funct3.
module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] lane;

  // NOTE: every output of a combinational block gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    lane   = rdata >> {addr_lo, 3'b000};
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{lane[7]}},  lane[7:0]};
      F3_H:    result = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   result = {24'd0, lane[7:0]};
      F3_HU:   result = {16'd0, lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle memory stage: accepts one load/store from the core, issues a
// word-aligned valid/grant request, waits for read data, and stalls the core.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_read,
  input  logic              op_write,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t  state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;

  logic        f3_legal;
  logic        candidate;
  logic        accept;
  logic        reject_misaligned;
  logic [31:0] aligned_rdata;

  // A candidate is a well-formed op; alignment then splits accept from reject.
  always_comb begin
    f3_legal          = op_read ? legal_load(op_funct3) : legal_store(op_funct3);
    candidate         = (state == IDLE) && op_valid && (op_read ^ op_write) && f3_legal;
    accept            = candidate && is_aligned(op_funct3, op_addr[1:0]);
    reject_misaligned = candidate && !is_aligned(op_funct3, op_addr[1:0]);
  end

  // Combinational so the core freezes in the very cycle the op is accepted.
  assign stall = accept || (state == REQ) || (state == WAIT);

  load_aligner u_aligner (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .result  (aligned_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_lo_q  <= 2'b00;
      funct3_q   <= F3_B;
      ld_data    <= '0;
      ld_valid   <= 1'b0;
      misaligned <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'b0000;
    end else begin
      ld_valid   <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= REQ;
            addr_lo_q <= op_addr[1:0];
            funct3_q  <= op_funct3;
            mem_req   <= 1'b1;
            mem_we    <= op_write;
            mem_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= byte_en(op_funct3, op_addr[1:0]);
            mem_wdata <= store_data(op_funct3, op_wdata);
          end else if (reject_misaligned) begin
            misaligned <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          // Only loads reach WAIT, so completion here always pulses ld_valid.
          if (mem_rvalid) begin
            ld_data  <= aligned_rdata;
            ld_valid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: loads, stores, grant
// back-pressure, misalignment, rejected ops and reset during a load.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_read, op_write;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        stall, ld_valid, misaligned;
  logic [31:0] ld_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_read    (op_read),
    .op_write   (op_write),
    .op_funct3  (op_funct3),
    .op_addr    (op_addr),
    .op_wdata   (op_wdata),
    .stall      (stall),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0;
    op_funct3 = 3'b000; op_addr = 32'h0; op_wdata = 32'h0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp_addr,
                          input logic [31:0] exp_be, input logic [31:0] exp_data);
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = f3; op_addr = addr;
    #1;
    check({tag, "_stall_accept"}, stall, 1);
    tick();
    idle_inputs();
    check({tag, "_req"},   mem_req,  1);
    check({tag, "_we"},    mem_we,   0);
    check({tag, "_addr"},  mem_addr, exp_addr);
    check({tag, "_be"},    mem_be,   exp_be);
    check({tag, "_stall_req"}, stall, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"},   mem_req,  0);
    check({tag, "_stall_wait"}, stall,    1);
    check({tag, "_noval_wait"}, ld_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check({tag, "_ld_valid"},   ld_valid, 1);
    check({tag, "_ld_data"},    ld_data,  exp_data);
    check({tag, "_stall_done"}, stall,    0);
    tick();
    check({tag, "_ld_valid_end"}, ld_valid, 0);
    check({tag, "_ld_data_hold"}, ld_data,  exp_data);
  endtask

  initial begin
    idle_inputs();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("rst_stall",      stall,      0);
    check("rst_req",        mem_req,    0);
    check("rst_we",         mem_we,     0);
    check("rst_addr",       mem_addr,   0);
    check("rst_wdata",      mem_wdata,  0);
    check("rst_be",         mem_be,     0);
    check("rst_ld_data",    ld_data,    0);
    check("rst_ld_valid",   ld_valid,   0);
    check("rst_misaligned", misaligned, 0);

    run_load("lw100",  3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 32'hF, 32'hDEADBEEF);
    run_load("lb103",  3'b000, 32'h103, 32'h80FF0000, 32'h100, 32'h8, 32'hFFFFFF80);
    run_load("lbu103", 3'b100, 32'h103, 32'h80FF0000, 32'h100, 32'h8, 32'h00000080);
    run_load("lh000",  3'b001, 32'h000, 32'h0000F00F, 32'h000, 32'h3, 32'hFFFFF00F);
    run_load("lhu302", 3'b101, 32'h302, 32'h80010000, 32'h300, 32'hC, 32'h00008001);

    // SH at 0x22 with the grant held off for four REQ cycles.
    op_valid = 1'b1; op_read = 1'b0; op_write = 1'b1; op_funct3 = 3'b001;
    op_addr = 32'h22; op_wdata = 32'h0000ABCD;
    #1;
    check("sh_stall_accept", stall, 1);
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check("sh_req",   mem_req,   1);
      check("sh_we",    mem_we,    1);
      check("sh_addr",  mem_addr,  32'h20);
      check("sh_be",    mem_be,    32'hC);
      check("sh_wdata", mem_wdata, 32'hABCDABCD);
      check("sh_stall", stall,     1);
      if (i == 4) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    check("sh_done_req",   mem_req,  0);
    check("sh_done_stall", stall,    0);
    check("sh_no_ldvalid", ld_valid, 0);
    tick();
    check("sh_ld_data_hold", ld_data, 32'h00008001);

    // SB at 0x5 replicates the byte and enables lane 1.
    op_valid = 1'b1; op_read = 1'b0; op_write = 1'b1; op_funct3 = 3'b000;
    op_addr = 32'h5; op_wdata = 32'h123456A5;
    tick();
    idle_inputs();
    check("sb_addr",  mem_addr,  32'h4);
    check("sb_be",    mem_be,    32'h2);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("sb_done_stall", stall, 0);
    tick();

    // Misaligned LW at 0x102.
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = 3'b010; op_addr = 32'h102;
    #1;
    check("mis_lw_stall", stall, 0);
    tick();
    idle_inputs();
    check("mis_lw_pulse", misaligned, 1);
    check("mis_lw_req",   mem_req,    0);
    tick();
    check("mis_lw_pulse_end", misaligned, 0);
    check("mis_lw_req2",      mem_req,    0);

    // Misaligned SH at 0x101.
    op_valid = 1'b1; op_read = 1'b0; op_write = 1'b1; op_funct3 = 3'b001;
    op_addr = 32'h101; op_wdata = 32'h1111;
    #1;
    check("mis_sh_stall", stall, 0);
    tick();
    idle_inputs();
    check("mis_sh_pulse", misaligned, 1);
    check("mis_sh_req",   mem_req,    0);
    tick();
    check("mis_sh_pulse_end", misaligned, 0);
    check("mis_sh_req2",      mem_req,    0);

    run_load("lw104", 3'b010, 32'h104, 32'h12345678, 32'h104, 32'hF, 32'h12345678);

    // Reset while waiting for read data; the late response must be dropped.
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = 3'b010; op_addr = 32'h200;
    tick();
    idle_inputs();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rstw_in_wait_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_req",     mem_req,  0);
    check("rstw_stall",   stall,    0);
    check("rstw_ld_data", ld_data,  0);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("rstw_late_valid", ld_valid, 0);
    check("rstw_late_data",  ld_data,  0);
    check("rstw_late_stall", stall,    0);
    tick();
    check("rstw_late_valid2", ld_valid, 0);

    // Both read and write set: ignored silently.
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b1; op_funct3 = 3'b010; op_addr = 32'h100;
    #1;
    check("rw_stall", stall, 0);
    tick();
    idle_inputs();
    check("rw_req",      mem_req,    0);
    check("rw_mis",      misaligned, 0);
    check("rw_ld_valid", ld_valid,   0);

    // Reserved funct3 011 on a load: ignored silently.
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_funct3 = 3'b011; op_addr = 32'h101;
    #1;
    check("f3res_stall", stall, 0);
    tick();
    idle_inputs();
    check("f3res_req",      mem_req,    0);
    check("f3res_mis",      misaligned, 0);
    check("f3res_ld_valid", ld_valid,   0);
    check("f3res_stall2",   stall,      0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
